branch_predictor_bht: RTL and testbench

// - Branch history table of 2-bit saturating counters; sits beside the IF stage and downstream of branchControlUnit.
// - Fetch PC gets a combinational taken/not-taken prediction each cycle.
// - Resolved outcome (Branch from branchControlUnit, in EX) updates the table and raises a registered mispredict/flush pulse.
// - Carries a table-clear FSM and saturating branch/mispredict statistics counters.

---
 rtl/branch_predictor_bht.sv | 134 +++++++++++++
 tb/tb_branch_predictor_bht.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters with a table-clear FSM and stats counters.
// Latency: prediction is combinational from fetch_pc; table writes and the mispredict pulse land one cycle after an update.
// Backpressure: none; while busy (clearing) updates are silently dropped and pred_taken reads 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_pc          PC being fetched -> pred_taken (counter MSB, forced 0 while busy)
//   upd_valid/pc/taken/pred  resolved conditional branch from EX, with the prediction used at IF
//   mispredict        registered one-cycle flush pulse
//   clear_req, busy   start a full-table reinitialisation / clear in progress
//   br_count, mp_count  saturating counts of accepted updates and mispredicts
module branch_predictor_bht #(
  parameter int N     = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     fetch_pc,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [N-1:0]     upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict,
  input  logic             clear_req,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [1:0] CNT_WNT = 2'b01;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       table_q [ENTRIES];
  logic             mispredict_q;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [1:0]       upd_cur, upd_nxt;
  logic             upd_acc, upd_mp;

  // Word-aligned PCs: bits [1:0] and everything above the index are not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[N-1:IDX_W+2], fetch_pc[1:0],
                            upd_pc[N-1:IDX_W+2], upd_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign upd_idx   = upd_pc[IDX_W+1:2];

  // Updates only count when the table is not being cleared.
  assign upd_acc = upd_valid && (state_q == IDLE);
  assign upd_mp  = upd_acc && (upd_taken != upd_pred);

  assign upd_cur = table_q[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
    end
  end

  // Clear FSM: walks ptr 0..ENTRIES-1, leaves on the edge where ptr is the last index.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd_acc && (br_count_q != '1)) br_count_d = br_count_q + 1'b1;
    if (upd_mp  && (mp_count_q != '1)) mp_count_d = mp_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      mispredict_q <= 1'b0;
      br_count_q   <= '0;
      mp_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mispredict_q <= upd_mp;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_WNT;
    end else if (state_q == CLEAR) begin
      table_q[ptr_q] <= CNT_WNT;
    end else if (upd_acc) begin
      table_q[upd_idx] <= upd_nxt;
    end
  end

  // No write bypass: a same-cycle update to the fetched entry shows up next cycle.
  assign pred_taken = (state_q == IDLE) && table_q[fetch_idx][1];
  assign busy       = (state_q == CLEAR);
  assign mispredict = mispredict_q;
  assign br_count   = br_count_q;
  assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 16)
  logic        rst_n, upd_valid, upd_taken, upd_pred, clear_req;
  logic [31:0] fetch_pc, upd_pc;
  logic        pred_taken, mispredict, busy;
  logic [15:0] br_count, mp_count;

  // Narrow-counter instance (CNT_W = 2)
  logic        rst2_n, upd_valid2, upd_taken2, upd_pred2, clear_req2;
  logic [31:0] fetch_pc2, upd_pc2;
  logic        pred_taken2, mispredict2, busy2;
  logic [1:0]  br_count2, mp_count2;

  int tests_run = 0;
  int tests_failed = 0;

  branch_predictor_bht #(.N(32), .IDX_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mispredict(mispredict), .clear_req(clear_req), .busy(busy),
    .br_count(br_count), .mp_count(mp_count)
  );

  branch_predictor_bht #(.N(32), .IDX_W(6), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .fetch_pc(fetch_pc2), .pred_taken(pred_taken2),
    .upd_valid(upd_valid2), .upd_pc(upd_pc2), .upd_taken(upd_taken2), .upd_pred(upd_pred2),
    .mispredict(mispredict2), .clear_req(clear_req2), .busy(busy2),
    .br_count(br_count2), .mp_count(mp_count2)
  );

  task automatic set_upd(input logic [31:0] pc, input logic taken, input logic pred);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    upd_pred  = pred;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0; clear_req = 1'b0;
    fetch_pc2 = '0; upd_valid2 = 1'b0; upd_pc2 = '0; upd_taken2 = 1'b0; upd_pred2 = 1'b0; clear_req2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (mispredict !== 1'b0) begin tests_failed++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
    tests_run++;
    if (br_count !== 16'd0) begin tests_failed++; $display("FAIL reset_br_count: got %0d want 0", br_count); end
    tests_run++;
    if (mp_count !== 16'd0) begin tests_failed++; $display("FAIL reset_mp_count: got %0d want 0", mp_count); end
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      tests_run++;
      if (pred_taken !== 1'b0) begin
        tests_failed++; $display("FAIL reset_pred[pc=0x%0h]: got %b want 0", fetch_pc, pred_taken);
      end
    end
  endtask

  // 01 -> 10 -> 11 -> 11; only the first update mispredicts.
  task automatic test_train();
    @(negedge clk);
    fetch_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h40, 1'b1, (k != 0));
      @(negedge clk);
      tests_run++;
      if (pred_taken !== 1'b1) begin
        tests_failed++; $display("FAIL train_pred[%0d]: got %b want 1", k, pred_taken);
      end
      tests_run++;
      if (mispredict !== (k == 0)) begin
        tests_failed++; $display("FAIL train_mispredict[%0d]: got %b want %b", k, mispredict, (k == 0));
      end
    end
    upd_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mispredict !== 1'b0) begin tests_failed++; $display("FAIL train_mp_after: got %b want 0", mispredict); end
    tests_run++;
    if (br_count !== 16'd3) begin tests_failed++; $display("FAIL train_br_count: got %0d want 3", br_count); end
    tests_run++;
    if (mp_count !== 16'd1) begin tests_failed++; $display("FAIL train_mp_count: got %0d want 1", mp_count); end
  endtask

  // 0x140 aliases 0x40: 11 -> 10 -> 01 -> 00, correctly predicted each time.
  task automatic test_alias();
    fetch_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h140, 1'b0, 1'b0);
      @(negedge clk);
      tests_run++;
      if (pred_taken !== (k == 0)) begin
        tests_failed++; $display("FAIL alias_pred[%0d]: got %b want %b", k, pred_taken, (k == 0));
      end
    end
    upd_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL alias_pred_final: got %b want 0", pred_taken); end
    tests_run++;
    if (br_count !== 16'd6 || mp_count !== 16'd1) begin
      tests_failed++; $display("FAIL alias_counts: got br=%0d mp=%0d want br=6 mp=1", br_count, mp_count);
    end
  endtask

  // Same index read and written: old value this cycle, new value next cycle.
  task automatic test_hazard();
    fetch_pc = 32'h80;
    set_upd(32'h80, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL hazard_same_cycle: got %b want 0", pred_taken); end
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    tests_run++;
    if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL hazard_next_cycle: got %b want 1", pred_taken); end
    tests_run++;
    if (mispredict !== 1'b1) begin tests_failed++; $display("FAIL hazard_mispredict: got %b want 1", mispredict); end
    @(negedge clk);
    tests_run++;
    if (br_count !== 16'd7 || mp_count !== 16'd2) begin
      tests_failed++; $display("FAIL hazard_counts: got br=%0d mp=%0d want br=7 mp=2", br_count, mp_count);
    end
  endtask

  task automatic test_back_to_back();
    set_upd(32'hC0, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (mispredict !== 1'b1) begin tests_failed++; $display("FAIL b2b_first: got %b want 1", mispredict); end
    set_upd(32'hC0, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++;
    if (mispredict !== 1'b1) begin tests_failed++; $display("FAIL b2b_second: got %b want 1", mispredict); end
    upd_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mispredict !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got %b want 0", mispredict); end
    tests_run++;
    if (br_count !== 16'd9 || mp_count !== 16'd4) begin
      tests_failed++; $display("FAIL b2b_counts: got br=%0d mp=%0d want br=9 mp=4", br_count, mp_count);
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    fetch_pc = 32'h40;
    // 0x40 is at 00 after the alias test; three correct taken updates take it to 11.
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h40, 1'b1, 1'b1);
      @(negedge clk);
    end
    upd_valid = 1'b0;
    #1;
    tests_run++;
    if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL clear_pretrain: got %b want 1", pred_taken); end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 5) set_upd(32'h40, 1'b0, 1'b1);
      if (n == 6) upd_valid = 1'b0;
      if (n == 10) clear_req = 1'b1;
      if (n == 11) clear_req = 1'b0;
      #1;
      if (pred_taken !== 1'b0 || mispredict !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    clear_req = 1'b0;
    tests_run++;
    if (n !== 64) begin tests_failed++; $display("FAIL clear_busy_cycles: got %0d want 64", n); end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL clear_outputs_while_busy: got %0d bad cycles want 0", bad); end
    tests_run++;
    if (mispredict !== 1'b0) begin tests_failed++; $display("FAIL clear_mp_after: got %b want 0", mispredict); end
    tests_run++;
    if (br_count !== 16'd12 || mp_count !== 16'd4) begin
      tests_failed++; $display("FAIL clear_counts: got br=%0d mp=%0d want br=12 mp=4", br_count, mp_count);
    end
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL clear_pred_after: got %b want 0", pred_taken); end
  endtask

  task automatic test_saturate_and_abort();
    rst2_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      upd_valid2 = 1'b1; upd_pc2 = 32'h0; upd_taken2 = 1'b1; upd_pred2 = 1'b0;
      @(negedge clk);
    end
    upd_valid2 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (br_count2 !== 2'd3) begin tests_failed++; $display("FAIL sat_br_count: got %0d want 3", br_count2); end
    tests_run++;
    if (mp_count2 !== 2'd3) begin tests_failed++; $display("FAIL sat_mp_count: got %0d want 3", mp_count2); end
    clear_req2 = 1'b1;
    @(negedge clk);
    clear_req2 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before: got %b want 1", busy2); end
    rst2_n = 1'b0;
    #1;
    tests_run++;
    if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL abort_busy_async: got %b want 0", busy2); end
    tests_run++;
    if (br_count2 !== 2'd0) begin tests_failed++; $display("FAIL abort_br_count: got %0d want 0", br_count2); end
    @(negedge clk);
    rst2_n = 1'b1;
    fetch_pc2 = 32'h0;
    @(negedge clk);
    tests_run++;
    if (busy2 !== 1'b0 || pred_taken2 !== 1'b0) begin
      tests_failed++; $display("FAIL abort_after: got busy=%b pred=%b want busy=0 pred=0", busy2, pred_taken2);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_hazard();
    test_back_to_back();
    test_clear();
    test_saturate_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
